mac_seq_unit: RTL
=================

# mac_seq_unit

Sequential, parametrised multiply-accumulate unit computing Z = A*B + C (unsigned, modulo 2^(2·WIDTH)), the iterative successor to the combinational 64×64+128 equation block. It retires DIGIT multiplier bits per cycle, trading latency for area. Valid/ready handshakes sit on both sides. It can optionally chain its own previous result as the addend, for dot-product style accumulation in the arithmetic datapath.

## Interface
- WIDTH, 64, operand width of A and B; Z and C are 2·WIDTH bits
- DIGIT, 1, multiplier bits consumed per cycle; legal values 1, 2, 4, 8; WIDTH % DIGIT must be 0, otherwise elaboration fails
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand set A/B/C/acc_sel is valid
- in_ready  output  1  unit can accept operands (high only in IDLE)
- A  input  WIDTH  multiplicand, unsigned
- B  input  WIDTH  multiplier, unsigned
- C  input  2·WIDTH  addend, unsigned; ignored when acc_sel=1
- acc_sel  input  1  1: addend is current Z register instead of C
- out_valid  output  1  Z holds a completed result
- out_ready  input  1  consumer accepts Z
- Z  output  2·WIDTH  result register; retains value after handshake
- busy  output  1  high in CALC or DONE

## Operation
- N = WIDTH/DIGIT iteration count.
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid: latch A, B and addend (acc_sel ? Z : C) into the accumulator, clear counter, go to CALC.
- CALC: each cycle, accumulator += (A · B_digit) << (count·DIGIT), where B_digit is the next DIGIT low bits of the shifting multiplier copy. Count increments. After the N-th iteration, write Z and go to DONE. A shift-right accumulator formulation is acceptable if the bit-exact result is identical.
- DONE: out_valid=1, Z stable. On out_ready, go to IDLE.
- Arithmetic: all additions are 2·WIDTH bits wide with carry out of the MSB discarded; the final Z = (A·B + addend) mod 2^(2·WIDTH).
- Z is updated only on the CALC→DONE transition. It is not cleared by the handshake, so acc_sel chains correctly across operations.
- in_valid while not in IDLE is ignored: no capture, no error.
- Reset asserted at any time, including mid-CALC: the operation is abandoned and everything returns to reset values.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, Z=0, accumulator=0, counter=0.
- acc_sel=1 on the first operation after reset uses addend 0.

## Timing
- Handshake accepted at edge t (IDLE, in_valid). CALC occupies edges t+1..t+N. out_valid is high from edge t+N onward.
- Latency from the input handshake edge to out_valid rising: N cycles. WIDTH=64: DIGIT=1 gives 64, DIGIT=4 gives 16.
- The output handshake at edge u returns the FSM to IDLE. in_ready is high in the cycle after u. The next accept is at earliest edge u+1.
- With out_ready held high, throughput is one operation per N+2 cycles.
- in_ready, out_valid and busy are decoded purely from registered state. There is no combinational path from any input to any output.
- Operands are sampled only at the accept edge. A, B, C and acc_sel may change freely afterwards.
- Z and out_valid hold indefinitely while out_ready=0 (backpressure).

## Test plan
- Zero and pass-through (WIDTH=64, DIGIT=1):
  - A=0, B=0, C=0 → Z=0.
  - A=64'h9e671e3d752a5420, B=0, C=128'h0026c160f19eb5f182168f26ab92c99b → Z=C; out_valid rises exactly 64 cycles after accept.
- Overflow wrap: A=B=all-ones, C=all-ones → Z=128'hffff_ffff_ffff_fffe_0000_0000_0000_0000; carry discarded. Repeat with DIGIT=4 → same Z at 16-cycle latency.
- Accumulate chain:
  - A=3, B=5, C=7, acc_sel=0 → Z=0x16.
  - Then A=2, B=4, C=0xFFFF, acc_sel=1 → Z=0x1E (C ignored).
- Backpressure and ignored input:
  - Hold out_ready=0 for 5 cycles in DONE → Z, out_valid stable, in_ready=0.
  - Pulse in_valid with new operands during CALC → result unaffected, no second operation starts.
- Reset mid-op: deassert rst_n 10 cycles into CALC → out_valid=0, Z=0, in_ready=1 immediately. A fresh A=3, B=5, C=7 after release → Z=0x16.

Source files
------------

// File: rtl/mac_seq_unit.sv
// ---------------------------------------------------------------------------
// mac_seq_unit
// Sequential multiply-accumulate unit computing Z = A*B + addend, where all
// values are unsigned and the result wraps modulo 2^(2*WIDTH). Each CALC
// cycle retires DIGIT multiplier bits, so one operation takes WIDTH/DIGIT
// cycles. The addend is either the C input or, when acc_sel=1, the unit's
// own previous result. This lets back-to-back operations build a dot product.
//
// Parameters:
//   WIDTH     operand width of A and B (Z and C are 2*WIDTH bits)
//   DIGIT     multiplier bits consumed per cycle (1, 2, 4 or 8)
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  operand set A/B/C/acc_sel is valid
//   in_ready  unit can accept operands (IDLE only)
//   A, B      multiplicand / multiplier
//   C         addend, ignored when acc_sel=1
//   acc_sel   1: use the current Z as the addend
//   out_valid Z holds a completed result
//   out_ready consumer accepts Z
//   Z         result register, kept after the output handshake
//   busy      high while calculating or holding a result
// ---------------------------------------------------------------------------
module mac_seq_unit #(
  parameter int WIDTH = 64,
  parameter int DIGIT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2*WIDTH-1:0]   C,
  input  logic                 acc_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   Z,
  output logic                 busy
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Refuse to elaborate with an unsupported digit size or one that does not
  // divide the operand width evenly.
  if (!(DIGIT == 1 || DIGIT == 2 || DIGIT == 4 || DIGIT == 8) ||
      (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("mac_seq_unit: illegal WIDTH/DIGIT combination");
  end

  logic [1:0]         state;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] a_shift;
  logic [WIDTH-1:0]   b_shift;
  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] acc_sum;

  // The multiplicand copy is pre-shifted left by DIGIT every cycle.
  // The current digit's partial product is therefore a plain sum of up to
  // DIGIT shifted copies, with no variable-distance barrel shifter.
  always_comb begin
    partial = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (b_shift[i]) begin
        partial = partial + (a_shift << i);
      end
    end
    acc_sum = acc + partial;
  end

  // Handshake flags come straight from the state register, so no input
  // ever reaches an output combinationally.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Main sequencer. Operands are captured once at the accept edge. Z is
  // written only when the last digit retires, and it is left untouched by
  // the output handshake so that acc_sel can chain results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      acc     <= '0;
      a_shift <= '0;
      b_shift <= '0;
      Z       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_shift <= {{WIDTH{1'b0}}, A};
            b_shift <= B;
            acc     <= acc_sel ? Z : C;
            count   <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          acc     <= acc_sum;
          a_shift <= a_shift << DIGIT;
          b_shift <= b_shift >> DIGIT;
          count   <= count + 1'b1;
          if (count == LAST) begin
            Z     <= acc_sum;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
